// File: rtl/mdio_45_pkg.sv
// rtl/mdio_45_pkg.sv - shared clause-45 MDIO frame constants and types
package mdio_45_pkg;

  // Opcodes as they appear in the OP field of the header
  localparam logic [1:0] OP_ADDR     = 2'b00;
  localparam logic [1:0] OP_WRITE    = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b11;
  localparam logic [1:0] OP_READ_INC = 2'b10;

  // Clause-45 start code and the turnaround pattern the master drives
  localparam logic [1:0] ST_CODE = 2'b00;
  localparam logic [1:0] TA_PAT  = 2'b10;

  // Field lengths in MDC bits
  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_END
  } state_t;

  // Read-type opcodes hand the bus to the slave from TA onwards
  function automatic logic op_is_read(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_READ_INC);
  endfunction

  // Address and write opcodes keep the master driving for the whole frame
  function automatic logic op_drives_data(input logic [1:0] op);
    return (op == OP_ADDR) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// rtl/mdio_mdc_gen.sv - MDC phase generator with bit-boundary and sample ticks
module mdio_mdc_gen #(
  parameter int MDC_HALF = 5
) (
  input  logic clk_25m,
  input  logic rst_n,
  input  logic abort,
  input  logic run,
  output logic mdc,
  output logic fall_tick,
  output logic sample_tick
);

  localparam int TW = $clog2(MDC_HALF);
  localparam logic [TW-1:0] TICK_LAST = TW'(MDC_HALF - 1);

  logic [TW-1:0] tick;
  logic          phase;

  // Tick counter and phase; held at the start of a low phase whenever not running
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      tick  <= '0;
      phase <= 1'b0;
    end else if (abort || !run) begin
      tick  <= '0;
      phase <= 1'b0;
    end else if (tick == TICK_LAST) begin
      tick  <= '0;
      phase <= ~phase;
    end else begin
      tick <= tick + TW'(1);
    end
  end

  assign mdc = phase;

  // The last high-phase cycle both ends the bit and is where the input is sampled
  assign fall_tick   = run && phase && (tick == TICK_LAST);
  assign sample_tick = run && phase && (tick == TICK_LAST);

endmodule

// File: rtl/mdio_master_45.sv
// rtl/mdio_master_45.sv - clause-45 MDIO master, one frame per accepted command
module mdio_master_45
  import mdio_45_pkg::*;
#(
  parameter int MDC_HALF = 5,
  parameter int PRE_LEN  = 32
) (
  input  logic        clk_25m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_prtad,
  input  logic [4:0]  cmd_devad,
  input  logic [15:0] cmd_data,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int FRAME_BITS = PRE_LEN + HDR_BITS + TA_BITS + DATA_BITS;
  localparam int BW = $clog2(FRAME_BITS);

  // Bit index of the first bit of each field, and of the last bit of each field
  localparam logic [BW-1:0] HDR_IDX  = BW'(PRE_LEN);
  localparam logic [BW-1:0] TA_IDX   = BW'(PRE_LEN + HDR_BITS);
  localparam logic [BW-1:0] DATA_IDX = BW'(PRE_LEN + HDR_BITS + TA_BITS);
  localparam logic [BW-1:0] PRE_END  = BW'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
  localparam logic [BW-1:0] HDR_END  = BW'(PRE_LEN + HDR_BITS - 1);
  localparam logic [BW-1:0] TA_END   = BW'(PRE_LEN + HDR_BITS + TA_BITS - 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(FRAME_BITS - 1);

  // A zero-length preamble goes straight to the header
  localparam state_t FIRST_STATE = (PRE_LEN > 0) ? S_PRE : S_HDR;

  state_t        state;
  state_t        state_next;
  logic [1:0]    op_q;
  logic [4:0]    prtad_q;
  logic [4:0]    devad_q;
  logic [15:0]   data_q;
  logic [BW-1:0] bit_idx;
  logic [1:0]    sync;
  logic          ta_err;
  logic [14:0]   shift;

  logic          accept;
  logic          run;
  logic          bit_end;
  logic          sample;
  logic          rd;
  logic [13:0]   hdr_word;
  logic [3:0]    hdr_pos;
  logic          ta_pos;
  logic [3:0]    data_pos;

  assign accept   = (state == S_IDLE) && enable && cmd_valid;
  assign run      = enable && (state inside {S_PRE, S_HDR, S_TA, S_DATA});
  assign rd       = op_is_read(op_q);
  assign hdr_word = {ST_CODE, op_q, prtad_q, devad_q};
  assign hdr_pos  = 4'(bit_idx - HDR_IDX);
  assign ta_pos   = 1'(bit_idx - TA_IDX);
  assign data_pos = 4'(bit_idx - DATA_IDX);

  mdio_mdc_gen #(
    .MDC_HALF(MDC_HALF)
  ) u_mdc_gen (
    .clk_25m    (clk_25m),
    .rst_n      (rst_n),
    .abort      (!enable),
    .run        (run),
    .mdc        (mdc),
    .fall_tick  (bit_end),
    .sample_tick(sample)
  );

  // FSM state register
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state; dropping enable wins over every other transition, including END
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cmd_valid) state_next = FIRST_STATE;
        S_PRE:  if (bit_end && bit_idx == PRE_END) state_next = S_HDR;
        S_HDR:  if (bit_end && bit_idx == HDR_END) state_next = S_TA;
        S_TA:   if (bit_end && bit_idx == TA_END) state_next = S_DATA;
        S_DATA: if (bit_end && bit_idx == LAST_IDX) state_next = S_END;
        S_END:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs; the pad is released (driven high, oe low) outside the frame
  always_comb begin
    cmd_ready = enable && (state == S_IDLE);
    rsp_valid = (state == S_END);
    mdio_oe   = 1'b0;
    mdio_o    = 1'b1;
    case (state)
      S_PRE: begin
        mdio_oe = 1'b1;
        mdio_o  = 1'b1;
      end
      S_HDR: begin
        mdio_oe = 1'b1;
        mdio_o  = hdr_word[4'(HDR_BITS - 1) - hdr_pos];
      end
      S_TA: begin
        if (op_drives_data(op_q)) begin
          mdio_oe = 1'b1;
          mdio_o  = ta_pos ? TA_PAT[0] : TA_PAT[1];
        end
      end
      S_DATA: begin
        if (op_drives_data(op_q)) begin
          mdio_oe = 1'b1;
          mdio_o  = data_q[4'(DATA_BITS - 1) - data_pos];
        end
      end
      default: begin
        mdio_oe = 1'b0;
        mdio_o  = 1'b1;
      end
    endcase
  end

  // Command fields are captured only on the accept cycle
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADDR;
      prtad_q <= '0;
      devad_q <= '0;
      data_q  <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      prtad_q <= cmd_prtad;
      devad_q <= cmd_devad;
      data_q  <= cmd_data;
    end
  end

  // Frame bit index; advances at each bit boundary and returns to zero after the last bit
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (!run) begin
      bit_idx <= '0;
    end else if (bit_end) begin
      bit_idx <= (bit_idx == LAST_IDX) ? '0 : bit_idx + BW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous pad input, idling high like the bus
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], mdio_i};
    end
  end

  // Read capture; the response registers change only on the way into END
  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      ta_err    <= 1'b0;
      shift     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (sample && state == S_TA && bit_idx == TA_END) begin
        ta_err <= sync[1];
      end
      if (sample && state == S_DATA) begin
        shift <= {shift[13:0], sync[1]};
      end
      if (state_next == S_END) begin
        rsp_err <= rd && ta_err;
        if (rd) begin
          rsp_rdata <= {shift, sync[1]};
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master_45.sv
// tb/tb_mdio_master_45.sv - self-checking bench for mdio_master_45
module tb_mdio_master_45;

  localparam int H         = 5;
  localparam int BITS      = 64;
  localparam int FRAME_CYC = BITS * 2 * H;

  logic        clk_25m = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_prtad = 5'd0;
  logic [4:0]  cmd_devad = 5'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_oe;
  logic        mdio_i = 1'b1;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] model_rdata = 16'h0000;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  prtad;
    logic [4:0]  devad;
    logic [15:0] data;
    logic [15:0] sdata;
    logic        ta2;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  mdio_master_45 #(
    .MDC_HALF(H),
    .PRE_LEN (32)
  ) dut (
    .clk_25m  (clk_25m),
    .rst_n    (rst_n),
    .enable   (enable),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_prtad(cmd_prtad),
    .cmd_devad(cmd_devad),
    .cmd_data (cmd_data),
    .mdc      (mdc),
    .mdio_o   (mdio_o),
    .mdio_oe  (mdio_oe),
    .mdio_i   (mdio_i),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #20 clk_25m = ~clk_25m;

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Expected serial frame: preamble, ST, OP, PRTAD, DEVAD, TA, DATA (bit 0 at MSB)
  function automatic logic [63:0] ref_o(input logic [1:0] op, input logic [4:0] pa,
                                        input logic [4:0] da, input logic [15:0] data);
    return {32'hFFFF_FFFF, 2'b00, op, pa, da,
            (op[1] ? 2'b11 : 2'b10), (op[1] ? 16'hFFFF : data)};
  endfunction

  function automatic logic [63:0] ref_oe(input logic [1:0] op);
    return op[1] ? {{46{1'b1}}, {18{1'b0}}} : {64{1'b1}};
  endfunction

  // Called and returns at #1 after a rising edge
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(posedge clk_25m);
      #1;
      n++;
    end
    check({name, " ready"}, 64'(cmd_ready), 64'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [4:0] pa, input logic [4:0] da,
                       input logic [15:0] data);
    cmd_op    = op;
    cmd_prtad = pa;
    cmd_devad = da;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk_25m);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] da, input logic [15:0] data,
                           input logic [15:0] sdata, input logic ta2,
                           input logic [15:0] exp_rdata, input logic exp_err);
    logic [63:0] got_o;
    logic [63:0] got_oe;
    int bad_stable, bad_mdc, bad_early, bad_ready, b, p;
    got_o = '0;
    got_oe = '0;
    bad_stable = 0;
    bad_mdc = 0;
    bad_early = 0;
    bad_ready = 0;
    wait_ready(name);
    issue(op, pa, da, data);
    for (int c = 1; c <= FRAME_CYC; c++) begin
      b = (c - 1) / (2 * H);
      p = (c - 1) % (2 * H);
      if (mdc !== (p >= H)) bad_mdc++;
      if (p == 0) begin
        got_o[63-b]  = mdio_o;
        got_oe[63-b] = mdio_oe;
      end else if (mdio_o !== got_o[63-b] || mdio_oe !== got_oe[63-b]) begin
        bad_stable++;
      end
      if (rsp_valid !== 1'b0) bad_early++;
      if (cmd_ready !== 1'b0) bad_ready++;
      if (b == 47) mdio_i = ta2;
      else if (b >= 48) mdio_i = sdata[63-b];
      else mdio_i = 1'b1;
      @(posedge clk_25m);
      #1;
    end
    mdio_i = 1'b1;
    check({name, " rsp_valid@641"}, 64'(rsp_valid), 64'd1);
    check({name, " end idle pins"}, {61'd0, mdc, mdio_oe, mdio_o}, 64'd1);
    check({name, " rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
    check({name, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
    check({name, " mdio_o bits"}, got_o, ref_o(op, pa, da, data));
    check({name, " mdio_oe bits"}, got_oe, ref_oe(op));
    check({name, " mdc shape errs"}, 64'(bad_mdc), 64'd0);
    check({name, " mid-bit changes"}, 64'(bad_stable), 64'd0);
    check({name, " early rsp_valid"}, 64'(bad_early), 64'd0);
    check({name, " busy cmd_ready"}, 64'(bad_ready), 64'd0);
    @(posedge clk_25m);
    #1;
    check({name, " rsp_valid pulse width"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [4:0]  r_pa;
    logic [4:0]  r_da;
    logic [15:0] r_data;
    logic [15:0] r_sd;
    logic        r_ta2;
    logic [15:0] r_exp;
    logic        r_err;
    int acc, rv, first_rv, last_rv, rv_abort;

    tbl[0] = '{2'b00, 5'h01, 5'h1E, 16'h0123, 16'h5A5A, 1'b1, 16'h0000, 1'b0};
    tbl[1] = '{2'b01, 5'h03, 5'h01, 16'hA5C3, 16'h3C3C, 1'b1, 16'h0000, 1'b0};
    tbl[2] = '{2'b11, 5'h01, 5'h1E, 16'h0000, 16'hBEEF, 1'b0, 16'hBEEF, 1'b0};
    tbl[3] = '{2'b01, 5'h1F, 5'h1F, 16'hFFFF, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
    tbl[4] = '{2'b11, 5'h02, 5'h03, 16'h0000, 16'h1234, 1'b1, 16'h1234, 1'b1};
    tbl[5] = '{2'b10, 5'h00, 5'h00, 16'h0000, 16'h0F0F, 1'b0, 16'h0F0F, 1'b0};
    tbl[6] = '{2'b00, 5'h00, 5'h00, 16'h0000, 16'hFFFF, 1'b0, 16'h0F0F, 1'b0};

    // Reset state
    enable = 1'b1;
    repeat (3) @(posedge clk_25m);
    #1;
    check("reset pins", {60'd0, mdc, mdio_oe, mdio_o, rsp_valid}, 64'b0010);
    check("reset rsp", {47'd0, rsp_rdata, rsp_err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk_25m);
    #1;
    check("post-reset cmd_ready", 64'(cmd_ready), 64'd1);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_frame($sformatf("tbl%0d", i), tbl[i].op, tbl[i].prtad, tbl[i].devad, tbl[i].data,
                tbl[i].sdata, tbl[i].ta2, tbl[i].exp_rdata, tbl[i].exp_err);
      model_rdata = tbl[i].exp_rdata;
    end

    // Random commands against the reference model
    for (int i = 0; i < 10; i++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_pa   = 5'($urandom);
      r_da   = 5'($urandom);
      r_data = 16'($urandom);
      r_sd   = 16'($urandom);
      r_ta2  = 1'($urandom);
      if (r_op[1]) begin
        r_exp = r_sd;
        r_err = r_ta2;
      end else begin
        r_exp = model_rdata;
        r_err = 1'b0;
      end
      run_frame($sformatf("rand%0d", i), r_op, r_pa, r_da, r_data, r_sd, r_ta2, r_exp, r_err);
      model_rdata = r_exp;
    end

    // Abort a write at bit 40 during the mdc-high phase
    wait_ready("abort");
    issue(2'b01, 5'h05, 5'h06, 16'h1357);
    for (int c = 1; c < 407; c++) begin
      @(posedge clk_25m);
      #1;
    end
    check("abort pre mdc high", 64'(mdc), 64'd1);
    enable = 1'b0;
    @(posedge clk_25m);
    #1;
    check("abort pins", {60'd0, mdc, mdio_oe, mdio_o, cmd_ready}, 64'b0010);
    rv_abort = 0;
    for (int c = 0; c < 700; c++) begin
      if (rsp_valid !== 1'b0) rv_abort++;
      @(posedge clk_25m);
      #1;
    end
    check("abort no rsp_valid", 64'(rv_abort), 64'd0);
    check("abort rsp_rdata kept", 64'(rsp_rdata), 64'(model_rdata));
    enable = 1'b1;
    run_frame("after abort", 2'b11, 5'h07, 5'h08, 16'h0000, 16'hC0DE, 1'b0, 16'hC0DE, 1'b0);
    model_rdata = 16'hC0DE;

    // cmd_valid held through two frames
    wait_ready("hold");
    cmd_op    = 2'b01;
    cmd_prtad = 5'h09;
    cmd_devad = 5'h0A;
    cmd_data  = 16'h2468;
    cmd_valid = 1'b1;
    acc = 0;
    rv = 0;
    first_rv = -1;
    last_rv = -1;
    for (int k = 0; k <= 1283; k++) begin
      if (cmd_ready === 1'b1) acc++;
      if (rsp_valid === 1'b1) begin
        rv++;
        if (first_rv < 0) first_rv = k;
        last_rv = k;
      end
      if (k == 1283) cmd_valid = 1'b0;
      @(posedge clk_25m);
      #1;
    end
    check("hold accepts", 64'(acc), 64'd2);
    check("hold rsp count", 64'(rv), 64'd2);
    check("hold first rsp cycle", 64'(first_rv), 64'd641);
    check("hold second rsp cycle", 64'(last_rv), 64'd1283);

    // Asynchronous reset in the middle of a read
    wait_ready("midreset");
    issue(2'b11, 5'h0B, 5'h0C, 16'h0000);
    for (int c = 1; c < 300; c++) begin
      @(posedge clk_25m);
      #1;
    end
    rst_n = 1'b0;
    #2;
    check("midreset pins", {60'd0, mdc, mdio_oe, mdio_o, rsp_valid}, 64'b0010);
    check("midreset rsp", {47'd0, rsp_rdata, rsp_err}, 64'd0);
    @(posedge clk_25m);
    #1;
    rst_n = 1'b1;
    model_rdata = 16'h0000;
    run_frame("post midreset", 2'b01, 5'h0D, 5'h0E, 16'h8001, 16'h7777, 1'b1, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdio_master_45.md
MDIO_MASTER_45 -- requirements
Module: mdio_master_45

Interface
REQ-001 SHALL have parameter MDC_HALF, default 5, giving clk_25m cycles per MDC half-period (MDC = 2.5 MHz); legal range 2..255.
REQ-002 SHALL have parameter PRE_LEN, default 32, giving the preamble length in bits.
REQ-003 SHALL have port clk_25m, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port enable, input, 1, block enable; low aborts and holds idle.
REQ-006 SHALL have port cmd_valid, input, 1, command request.
REQ-007 SHALL have port cmd_ready, output, 1, equal to enable AND state==IDLE.
REQ-008 SHALL have port cmd_op, input, 2, opcode: 00 address, 01 write, 11 read, 10 read-increment.
REQ-009 SHALL have port cmd_prtad, input, 5, port address.
REQ-010 SHALL have port cmd_devad, input, 5, device address.
REQ-011 SHALL have port cmd_data, input, 16, register address (op 00) or write data (op 01).
REQ-012 SHALL have port mdc, output, 1, management clock; low when idle.
REQ-013 SHALL have port mdio_o, output, 1, serial data out; 1 when not driving.
REQ-014 SHALL have port mdio_oe, output, 1, output enable for the pad.
REQ-015 SHALL have port mdio_i, input, 1, serial data in from the pad (asynchronous).
REQ-016 SHALL have port rsp_valid, output, 1, one-cycle frame-complete pulse.
REQ-017 SHALL have port rsp_rdata, output, 16, read data; held until the next read completes.
REQ-018 SHALL have port rsp_err, output, 1, valid with rsp_valid; read TA error.

Function
REQ-019 SHALL accept a command on the cycle where cmd_valid AND cmd_ready, latching op, prtad, devad and data.
REQ-020 SHALL run FSM IDLE->PRE->HDR->TA->DATA->END->IDLE. PRE lasts PRE_LEN bits; HDR lasts 14 bits (ST=00, OP, PRTAD, DEVAD, MSB first); TA lasts 2 bits; DATA lasts 16 bits, MSB first; END lasts one clk_25m cycle.
REQ-021 Each bit SHALL last 2*MDC_HALF cycles: mdc low for MDC_HALF cycles, then high for MDC_HALF cycles. mdio_o/mdio_oe SHALL change only on the cycle mdc goes low (first bit: cycle after accept).
REQ-022 For ops 00 and 01, SHALL drive TA=1,0 and DATA=cmd_data with mdio_oe=1 for the whole frame.
REQ-023 For ops 11 and 10, SHALL drive mdio_oe=0 from the first TA bit through the last DATA bit.
REQ-024 SHALL pass mdio_i through a 2-flop synchronizer and sample it on the last high-phase cycle of each bit. For reads, sampled DATA bits shift into rsp_rdata MSB first.
REQ-025 For reads, rsp_err SHALL be 1 if the sampled second TA bit is not 0. For ops 00 and 01, rsp_err SHALL be 0 and rsp_rdata SHALL be unchanged.
REQ-026 In END, SHALL pulse rsp_valid for exactly one cycle, with mdc=0, mdio_oe=0 and mdio_o=1. rsp_valid occurs (PRE_LEN+32)*2*MDC_HALF+1 cycles after the accept cycle (641 at defaults).
REQ-027 SHALL ignore cmd_valid while not IDLE; no queuing, and cmd_ready stays low.
REQ-028 When enable goes low mid-frame, SHALL abort on the next cycle: IDLE, mdc=0, mdio_oe=0, mdio_o=1, no rsp_valid, rsp_rdata unchanged. Abort SHALL take priority over an END cycle in the same clock.
REQ-029 Bit and tick counters SHALL saturate-free wrap: tick 0..MDC_HALF-1, bit index 0..PRE_LEN+31; no count beyond frame end.

Reset
REQ-030 On rst_n low, SHALL set state=IDLE, mdc=0, mdio_o=1, mdio_oe=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, synchronizer=1, and all counters=0.
REQ-031 Reset SHALL take effect mid-frame immediately, with no partial response.

Structure
REQ-032 Opcode constants, ST code, TA pattern, and header/data bit lengths SHALL live in shared package mdio_45_pkg, also used by the slave backend.
REQ-033 MDC tick/phase generation SHALL be one sub-module, mdio_mdc_gen (outputs mdc, fall_tick, sample_tick), reset by abort.

Verification
REQ-034 Address op: prtad=5'h01, devad=5'h1E, data=16'h0123 -> 32 ones, then 00 00 00001 11110 10 0000000100100011 on mdio_o; rsp_valid at cycle 641, rsp_err=0.
REQ-035 Write op 01, data=16'hA5C3 -> mdio_oe=1 for all 64 bits; TA=10; DATA=A5C3 MSB first; rsp_rdata unchanged.
REQ-036 Read op 11, with a slave model driving TA bit2=0 and data 16'hBEEF -> mdio_oe=0 from bit 46; rsp_rdata=16'hBEEF, rsp_err=0.
REQ-037 Read with the slave driving TA bit2=1 -> rsp_err=1 with rsp_valid.
REQ-038 enable dropped at bit 40 of a write -> next cycle mdc=0, mdio_oe=0, no rsp_valid; a new command is accepted once enable=1.
REQ-039 cmd_valid held high through a frame -> exactly one accept per frame; a second frame starts the cycle after END.
